// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Round-robin warp issue scheduler with a one-entry output register.
//   Each cycle it picks the first issue-ready warp at or after rr_ptr+1.
//   The warp issued on the previous cycle and a warp being flushed are both
//   masked out of the pick. The picked warp id reads the instruction buffer
//   combinationally. The entry is captured when the output register is
//   empty or is being drained in the same cycle.
//
//   Optional build macro: ISSUE_SCHEDULER_STATS_EN adds issue/stall counters.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   warp_ready_mask  per-warp issue-ready
//   ib_rd_warp_id    instruction-buffer read index (selected warp, 0 if none)
//   ib_instruction   buffer entry for ib_rd_warp_id, same cycle
//   m_tvalid_sb      one-cycle issue notification to scoreboard
//   target_warp      warp id qualified by m_tvalid_sb
//   m_tvalid         held instruction valid
//   m_tready         operand stage accepts
//   m_warp_id        warp of held instruction
//   m_instruction    held instruction
//   flush_valid      cancel request for one warp
//   flush_warp_id    warp to cancel
//   issue_count      (stats build) issues since reset, wraps at 2^32
//   stall_count      (stats build) cycles with m_tvalid=1 and m_tready=0
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | output register holds nothing
// HOLD  | output register holds an entry, m_tvalid=1

module issue_scheduler #(
    parameter int NUM_WARPS = 32,
    parameter int WARP_ID_W = 5,
    parameter int INSTR_W   = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WARPS-1:0] warp_ready_mask,
    output logic [WARP_ID_W-1:0] ib_rd_warp_id,
    input  logic [INSTR_W-1:0]   ib_instruction,
    output logic                 m_tvalid_sb,
    output logic [WARP_ID_W-1:0] target_warp,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [WARP_ID_W-1:0] m_warp_id,
    output logic [INSTR_W-1:0]   m_instruction,
    input  logic                 flush_valid,
    input  logic [WARP_ID_W-1:0] flush_warp_id
`ifdef ISSUE_SCHEDULER_STATS_EN
    ,
    output logic [31:0]          issue_count,
    output logic [31:0]          stall_count
`endif
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [WARP_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                 sb_valid_q, sb_valid_d;
    logic [WARP_ID_W-1:0] sb_warp_q, sb_warp_d;
    logic [WARP_ID_W-1:0] warp_id_q, warp_id_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic [NUM_WARPS-1:0] block;
    logic [NUM_WARPS-1:0] candidate;
    logic                 sel_valid;
    logic [WARP_ID_W-1:0] sel_id;
    logic [WARP_ID_W-1:0] idx_w;
    int unsigned          idx;
    logic                 issue;

    // The scoreboard notification register doubles as the last-issued record:
    // it is set exactly on the cycle after an issue.
    always_comb begin
        block = '0;
        if (sb_valid_q)  block[sb_warp_q]     = 1'b1;
        if (flush_valid) block[flush_warp_id] = 1'b1;
        candidate = warp_ready_mask & ~block;
    end

    // Search offsets 1..NUM_WARPS from rr_ptr; the last offset is rr_ptr itself.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = int'(unsigned'(rr_ptr_q)) + i;
            if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
            idx_w = WARP_ID_W'(idx);
            if (!sel_valid && candidate[idx_w]) begin
                sel_valid = 1'b1;
                sel_id    = idx_w;
            end
        end
    end

    assign ib_rd_warp_id = sel_id;
    assign issue = sel_valid && ((state_q == EMPTY) || m_tready);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sb_valid_d = issue;
        sb_warp_d  = sb_warp_q;
        warp_id_d  = warp_id_q;
        instr_d    = instr_q;
        if (issue) begin
            state_d   = HOLD;
            rr_ptr_d  = sel_id;
            sb_warp_d = sel_id;
            warp_id_d = sel_id;
            instr_d   = ib_instruction;
        end else if (state_q == HOLD) begin
            // A completing handshake takes priority over a flush of the same entry.
            if (m_tready)
                state_d = EMPTY;
            else if (flush_valid && (flush_warp_id == warp_id_q))
                state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= WARP_ID_W'(NUM_WARPS - 1);
            sb_valid_q <= 1'b0;
            sb_warp_q  <= '0;
            warp_id_q  <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sb_valid_q <= sb_valid_d;
            sb_warp_q  <= sb_warp_d;
            warp_id_q  <= warp_id_d;
            instr_q    <= instr_d;
        end
    end

    assign m_tvalid      = (state_q == HOLD);
    assign m_warp_id     = warp_id_q;
    assign m_instruction = instr_q;
    assign m_tvalid_sb   = sb_valid_q;
    assign target_warp   = sb_warp_q;

`ifdef ISSUE_SCHEDULER_STATS_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue)                   issue_cnt_q <= issue_cnt_q + 32'd1;
            if (m_tvalid && !m_tready)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] warp_ready_mask;
    logic [4:0]  ib_rd_warp_id;
    logic [62:0] ib_instruction;
    logic        m_tvalid_sb;
    logic [4:0]  target_warp;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  m_warp_id;
    logic [62:0] m_instruction;
    logic        flush_valid;
    logic [4:0]  flush_warp_id;
`ifdef ISSUE_SCHEDULER_STATS_EN
    logic [31:0] issue_count;
    logic [31:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [62:0] exp_instr(input logic [4:0] id);
        return {8'hA5, 50'h0_1234_5678_9ABC, id};
    endfunction

    // Instruction buffer model: entry content derived from the read index.
    assign ib_instruction = exp_instr(ib_rd_warp_id);

    issue_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .warp_ready_mask (warp_ready_mask),
        .ib_rd_warp_id   (ib_rd_warp_id),
        .ib_instruction  (ib_instruction),
        .m_tvalid_sb     (m_tvalid_sb),
        .target_warp     (target_warp),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_warp_id       (m_warp_id),
        .m_instruction   (m_instruction),
        .flush_valid     (flush_valid),
        .flush_warp_id   (flush_warp_id)
`ifdef ISSUE_SCHEDULER_STATS_EN
        ,
        .issue_count     (issue_count),
        .stall_count     (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] mask, input logic rdy,
                         input logic fv, input logic [4:0] fid);
        warp_ready_mask = mask;
        m_tready        = rdy;
        flush_valid     = fv;
        flush_warp_id   = fid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 5'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] w,
                           input logic sb, input logic [4:0] t);
        chk({tag, ".m_tvalid"}, 64'(m_tvalid), 64'(v));
        if (v) begin
            chk({tag, ".m_warp_id"}, 64'(m_warp_id), 64'(w));
            chk({tag, ".m_instruction"}, 64'(m_instruction), 64'(exp_instr(w)));
        end
        chk({tag, ".m_tvalid_sb"}, 64'(m_tvalid_sb), 64'(sb));
        if (sb) chk({tag, ".target_warp"}, 64'(target_warp), 64'(t));
    endtask

    typedef struct {
        logic [31:0] mask;
        logic        rdy;
        logic        fv;
        logic [4:0]  fid;
        logic [4:0]  exp_rd;
        logic        exp_v;
        logic [4:0]  exp_w;
        logic        exp_sb;
        logic [4:0]  exp_t;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic [31:0] mask, input logic rdy, input logic fv,
                                input logic [4:0] fid, input logic [4:0] rd, input logic v,
                                input logic [4:0] w, input logic sb, input logic [4:0] t);
        vec_t r;
        r.mask = mask; r.rdy = rdy; r.fv = fv; r.fid = fid; r.exp_rd = rd;
        r.exp_v = v; r.exp_w = w; r.exp_sb = sb; r.exp_t = t;
        return r;
    endfunction

    initial begin
        logic [4:0] w;
        bit done;
        //          mask          rdy fv fid  rd  v  w   sb t
        vt[0]  = mk(32'h0000_0001, 1, 0, 0,   0,  1, 0,  1, 0);
        vt[1]  = mk(32'h0000_0001, 1, 0, 0,   0,  0, 0,  0, 0);
        vt[2]  = mk(32'h0000_0001, 1, 0, 0,   0,  1, 0,  1, 0);
        vt[3]  = mk(32'h8000_0001, 1, 0, 0,  31,  1, 31, 1, 31);
        vt[4]  = mk(32'h8000_0001, 1, 0, 0,   0,  1, 0,  1, 0);
        vt[5]  = mk(32'h8000_0001, 1, 0, 0,  31,  1, 31, 1, 31);
        vt[6]  = mk(32'h0000_00F0, 0, 0, 0,   4,  1, 31, 0, 0);
        vt[7]  = mk(32'h0000_00F0, 1, 0, 0,   4,  1, 4,  1, 4);
        vt[8]  = mk(32'h0000_00F0, 1, 0, 0,   5,  1, 5,  1, 5);
        vt[9]  = mk(32'h0000_0020, 1, 0, 0,   0,  0, 0,  0, 0);
        vt[10] = mk(32'h0000_0020, 0, 0, 0,   5,  1, 5,  1, 5);
        vt[11] = mk(32'h0000_0020, 0, 0, 0,   0,  1, 5,  0, 0);
        vt[12] = mk(32'h0000_0020, 0, 1, 5,   0,  0, 0,  0, 0);
        vt[13] = mk(32'h0000_0000, 0, 0, 0,   0,  0, 0,  0, 0);

        // Reset state
        do_reset();
        #1;
        chk("reset.m_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset.m_tvalid_sb", 64'(m_tvalid_sb), 64'd0);
        chk("reset.target_warp", 64'(target_warp), 64'd0);
        chk("reset.m_warp_id", 64'(m_warp_id), 64'd0);
        chk("reset.m_instruction", 64'(m_instruction), 64'd0);
`ifdef ISSUE_SCHEDULER_STATS_EN
        chk("reset.issue_count", 64'(issue_count), 64'd0);
        chk("reset.stall_count", 64'(stall_count), 64'd0);
`endif

        // Table-driven vectors
        foreach (vt[i]) begin
            drive(vt[i].mask, vt[i].rdy, vt[i].fv, vt[i].fid);
            #1;
            chk($sformatf("vec%0d.ib_rd_warp_id", i), 64'(ib_rd_warp_id), 64'(vt[i].exp_rd));
            step();
            chk_out($sformatf("vec%0d", i), vt[i].exp_v, vt[i].exp_w, vt[i].exp_sb, vt[i].exp_t);
        end

        // Full round robin: 0..31 then 0
        do_reset();
        drive(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 33; i++) begin
            w = 5'(i % 32);
            step();
            chk_out($sformatf("rr%0d", i), 1'b1, w, 1'b1, w);
        end

        // Hold warp 7 for 5 stalled cycles
        do_reset();
        drive(32'h0000_0080, 1'b0, 1'b0, 5'd0);
        step();
        chk_out("stall.issue", 1'b1, 5'd7, 1'b1, 5'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 1'b1, 5'd7, 1'b0, 5'd0);
        end
`ifdef ISSUE_SCHEDULER_STATS_EN
        chk("stall.stall_count", 64'(stall_count), 64'd5);
        chk("stall.issue_count", 64'(issue_count), 64'd1);
`endif
        drive(32'h0, 1'b1, 1'b0, 5'd0);
        step();
        chk_out("stall.drain", 1'b0, 5'd0, 1'b0, 5'd0);

        // Flush of held warp 3 while stalled, then with a completing handshake
        do_reset();
        drive(32'h0000_0008, 1'b0, 1'b0, 5'd0);
        step();
        chk_out("flush.issue", 1'b1, 5'd3, 1'b1, 5'd3);
        drive(32'h0, 1'b0, 1'b1, 5'd3);
        step();
        chk_out("flush.drop", 1'b0, 5'd0, 1'b0, 5'd0);
        drive(32'h0000_0008, 1'b0, 1'b0, 5'd0);
        step();
        chk_out("flush.reissue", 1'b1, 5'd3, 1'b1, 5'd3);
        drive(32'h0000_0010, 1'b1, 1'b1, 5'd3);
        step();
        chk_out("flush.handshake", 1'b1, 5'd4, 1'b1, 5'd4);
        // Flush of a warp other than the held one has no effect on the entry
        drive(32'h0, 1'b0, 1'b1, 5'd9);
        step();
        chk_out("flush.other", 1'b1, 5'd4, 1'b0, 5'd0);

        // Reset while holding; pointer and block mask must restart
        do_reset();
        drive(32'h0000_0002, 1'b0, 1'b0, 5'd0);
        step();
        chk_out("rstmid.issue", 1'b1, 5'd1, 1'b1, 5'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("rstmid.reset", 1'b0, 5'd0, 1'b0, 5'd0);
        chk("rstmid.m_warp_id", 64'(m_warp_id), 64'd0);
        drive(32'h0000_0006, 1'b1, 1'b0, 5'd0);
        #1;
        chk("rstmid.ib_rd_warp_id", 64'(ib_rd_warp_id), 64'd1);
        step();
        chk_out("rstmid.first", 1'b1, 5'd1, 1'b1, 5'd1);

        // Bounded wait: stalled entry must drain within a few cycles once ready
        drive(32'h0, 1'b1, 1'b0, 5'd0);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (!m_tvalid) done = 1'b1;
        end
        chk("drain.timeout", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
